id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: none; widths fixed at 32-bit data, 5-bit register index, 32 registers.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears pipeline register and register file.
REQ-004 IF_ID_NPC  in  32  incremented PC from fetch.
REQ-005 IF_ID_IR  in  32  fetched instruction.
REQ-006 PC_choose  in  1  branch taken in MEM; flush the decode slot.
REQ-007 MEM_WB_RegWrite  in  1  writeback enable.
REQ-008 MEM_WB_rd  in  5  writeback register index.
REQ-009 MEM_WB_data  in  32  writeback data.
REQ-010 ID_EX_WB  out  2  {RegWrite, MemtoReg}.
REQ-011 ID_EX_M  out  3  {Branch, MemRead, MemWrite}.
REQ-012 ID_EX_EX  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
REQ-013 ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_imm  out  32 each  registered NPC, rs value, rt value, sign-extended IR[15:0].
REQ-014 ID_EX_rt, ID_EX_rd  out  5 each  registered IR[20:16], IR[15:11].
REQ-015 stall  out  1  combinational load-use hazard; fetch holds PC and IF/ID while high.

Function
REQ-016 Fields: opcode=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], imm=IR[15:0].
REQ-017 Decode: opcode 0 -> WB=10, M=000, EX=1100; 35 (lw) -> WB=11, M=010, EX=0001; 43 (sw) -> WB=00, M=001, EX=0001; 4 (beq) -> WB=00, M=100, EX=0010; any other -> all control zero (NOP).
REQ-018 Register file: 32x32; combinational read of rs and rt; write on rising edge when MEM_WB_RegWrite=1 and MEM_WB_rd!=0.
REQ-019 Register 0 reads 0 always; writes to it are ignored.
REQ-020 Latency: one cycle; all ID_EX_* outputs update on the rising edge after IF_ID_IR is presented.
REQ-021 ID_EX_imm = {16{IR[15]}, IR[15:0]}.
REQ-022 stall = ID_EX_M[1] and ID_EX_rt!=0 and (ID_EX_rt==rs or ID_EX_rt==rt).
REQ-023 Bubble: when stall=1 or PC_choose=1, next ID_EX_WB/M/EX SHALL be zero; data fields still load.
REQ-024 stall SHALL last exactly one cycle per load-use pair, since the bubble clears ID_EX_M[1].
REQ-025 PC_choose and stall together: single bubble, no extra cycle.

Reset
REQ-026 While reset=1: all ID_EX_* outputs 0, all 32 registers 0, stall 0 regardless of inputs.
REQ-027 Reset asserted mid-operation discards in-flight decode and any same-cycle writeback.
REQ-028 First rising edge after reset deassertion captures decode normally.

Configuration
REQ-029 Macro WB_BYPASS_EN: when defined, a read of rs/rt equal to MEM_WB_rd (nonzero) with MEM_WB_RegWrite=1 returns MEM_WB_data in the same cycle.
REQ-030 Without WB_BYPASS_EN: same-cycle read returns the pre-write register value; new value visible from the next cycle.

Verification
REQ-031 Reset, then IR=0x012A4020 (add $8,$9,$10) with $9=5, $10=7 preloaded -> next edge ID_EX_A=5, ID_EX_B=7, WB=10, EX=1100, rd=8.
REQ-032 IR=0x8D28FFFC (lw $8,-4($9)) -> ID_EX_imm=0xFFFFFFFC, M=010, EX=0001, rt=8.
REQ-033 lw $8 in EX, IR=add using $8 -> stall=1 one cycle, ID_EX controls 0, add decoded on following edge with stall=0.
REQ-034 Writeback rd=0, data=0xDEADBEEF -> later read of $0 returns 0.
REQ-035 Writeback rd=9, data=0x1234 same cycle as read of $9 -> ID_EX_A=0x1234 with WB_BYPASS_EN, old value without.
REQ-036 PC_choose=1 with valid R-type -> ID_EX_WB/M/EX all 0; reset asserted between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS-style decode stage: control decode, 32x32 register file, ID/EX register, load-use stall.
// Optional same-cycle writeback-to-read bypass is enabled by defining WB_BYPASS_EN.
module id_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IF_ID_NPC,
    input  logic [31:0] IF_ID_IR,
    input  logic        PC_choose,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_rd,
    input  logic [31:0] MEM_WB_data,
    output logic [1:0]  ID_EX_WB,
    output logic [2:0]  ID_EX_M,
    output logic [3:0]  ID_EX_EX,
    output logic [31:0] ID_EX_NPC,
    output logic [31:0] ID_EX_A,
    output logic [31:0] ID_EX_B,
    output logic [31:0] ID_EX_imm,
    output logic [4:0]  ID_EX_rt,
    output logic [4:0]  ID_EX_rd,
    output logic        stall
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign opcode = IF_ID_IR[31:26];
    assign rs     = IF_ID_IR[25:21];
    assign rt     = IF_ID_IR[20:16];
    assign rd     = IF_ID_IR[15:11];
    assign imm    = IF_ID_IR[15:0];

    logic [31:0] regs_q [32];
    logic        wb_en;

    assign wb_en = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wb_en) begin
            regs_q[MEM_WB_rd] <= MEM_WB_data;
        end
    end

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // Register 0 is never written, so a plain array read already yields zero for it.
    always_comb begin
        rs_val = regs_q[rs];
        rt_val = regs_q[rt];
`ifdef WB_BYPASS_EN
        if (wb_en && (MEM_WB_rd == rs)) begin
            rs_val = MEM_WB_data;
        end
        if (wb_en && (MEM_WB_rd == rt)) begin
            rt_val = MEM_WB_data;
        end
`endif
    end

    logic [1:0] wb_dec;
    logic [2:0] m_dec;
    logic [3:0] ex_dec;

    always_comb begin
        wb_dec = 2'b00;
        m_dec  = 3'b000;
        ex_dec = 4'b0000;
        case (opcode)
            OP_RTYPE: begin
                wb_dec = 2'b10;
                ex_dec = 4'b1100;
            end
            OP_LW: begin
                wb_dec = 2'b11;
                m_dec  = 3'b010;
                ex_dec = 4'b0001;
            end
            OP_SW: begin
                m_dec  = 3'b001;
                ex_dec = 4'b0001;
            end
            OP_BEQ: begin
                m_dec  = 3'b100;
                ex_dec = 4'b0010;
            end
            default: ;
        endcase
    end

    logic [1:0]  wb_q,  wb_d;
    logic [2:0]  m_q,   m_d;
    logic [3:0]  ex_q,  ex_d;
    logic [31:0] npc_q, a_q, b_q, imm_q;
    logic [4:0]  rt_q,  rd_q;
    logic        bubble;

    // A load in EX whose destination feeds this instruction must wait one cycle.
    assign stall  = m_q[1] && (rt_q != 5'd0) && ((rt_q == rs) || (rt_q == rt));
    assign bubble = stall || PC_choose;

    assign wb_d = bubble ? 2'b00   : wb_dec;
    assign m_d  = bubble ? 3'b000  : m_dec;
    assign ex_d = bubble ? 4'b0000 : ex_dec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_q  <= 2'b00;
            m_q   <= 3'b000;
            ex_q  <= 4'b0000;
            npc_q <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            imm_q <= 32'd0;
            rt_q  <= 5'd0;
            rd_q  <= 5'd0;
        end else begin
            wb_q  <= wb_d;
            m_q   <= m_d;
            ex_q  <= ex_d;
            npc_q <= IF_ID_NPC;
            a_q   <= rs_val;
            b_q   <= rt_val;
            imm_q <= {{16{imm[15]}}, imm};
            rt_q  <= rt;
            rd_q  <= rd;
        end
    end

    assign ID_EX_WB  = wb_q;
    assign ID_EX_M   = m_q;
    assign ID_EX_EX  = ex_q;
    assign ID_EX_NPC = npc_q;
    assign ID_EX_A   = a_q;
    assign ID_EX_B   = b_q;
    assign ID_EX_imm = imm_q;
    assign ID_EX_rt  = rt_q;
    assign ID_EX_rd  = rd_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with directed decode, hazard, bypass and reset vectors.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IF_ID_NPC = '0;
    logic [31:0] IF_ID_IR = '0;
    logic        PC_choose = 1'b0;
    logic        MEM_WB_RegWrite = 1'b0;
    logic [4:0]  MEM_WB_rd = '0;
    logic [31:0] MEM_WB_data = '0;
    logic [1:0]  ID_EX_WB;
    logic [2:0]  ID_EX_M;
    logic [3:0]  ID_EX_EX;
    logic [31:0] ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_imm;
    logic [4:0]  ID_EX_rt, ID_EX_rd;
    logic        stall;

    id_stage dut (
        .clock(clock), .reset(reset),
        .IF_ID_NPC(IF_ID_NPC), .IF_ID_IR(IF_ID_IR), .PC_choose(PC_choose),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_data(MEM_WB_data),
        .ID_EX_WB(ID_EX_WB), .ID_EX_M(ID_EX_M), .ID_EX_EX(ID_EX_EX),
        .ID_EX_NPC(ID_EX_NPC), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_imm(ID_EX_imm),
        .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd), .stall(stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        bit          is_stall;
        string       name;
        logic        st;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, a, b, imm;
        logic [4:0]  rt, rd;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (e.is_stall) begin
                if (stall !== e.st || e.due != cyc) begin
                    bad++;
                    $display("FAIL %s stall: got=%0b want=%0b (cycle %0d due %0d)", e.name, stall, e.st, cyc, e.due);
                end
            end else if (e.due != cyc ||
                         {ID_EX_WB, ID_EX_M, ID_EX_EX} !== {e.wb, e.m, e.ex} ||
                         {ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_imm} !== {e.npc, e.a, e.b, e.imm} ||
                         {ID_EX_rt, ID_EX_rd} !== {e.rt, e.rd}) begin
                bad++;
                $display("FAIL %s idex: got wb=%b m=%b ex=%b npc=%h a=%h b=%h imm=%h rt=%0d rd=%0d want wb=%b m=%b ex=%b npc=%h a=%h b=%h imm=%h rt=%0d rd=%0d",
                         e.name, ID_EX_WB, ID_EX_M, ID_EX_EX, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_imm, ID_EX_rt, ID_EX_rd,
                         e.wb, e.m, e.ex, e.npc, e.a, e.b, e.imm, e.rt, e.rd);
            end
        end
    end

    // Drive one decode slot: stall is judged this cycle, ID/EX contents after the next edge.
    task automatic step(input string name,
                        input logic [31:0] npc, input logic [31:0] ir, input logic pcc,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic est, input logic [1:0] ewb, input logic [2:0] em, input logic [3:0] eex,
                        input logic [31:0] enpc, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] eimm, input logic [4:0] ert, input logic [4:0] erd);
        exp_t e;
        IF_ID_NPC       = npc;
        IF_ID_IR        = ir;
        PC_choose       = pcc;
        MEM_WB_RegWrite = we;
        MEM_WB_rd       = wrd;
        MEM_WB_data     = wd;
        e.due = cyc; e.is_stall = 1'b1; e.name = name; e.st = est;
        e.wb = '0; e.m = '0; e.ex = '0; e.npc = '0; e.a = '0; e.b = '0; e.imm = '0; e.rt = '0; e.rd = '0;
        exp_q.push_back(e);
        e.due = cyc + 1; e.is_stall = 1'b0;
        e.wb = ewb; e.m = em; e.ex = eex; e.npc = enpc; e.a = ea; e.b = eb; e.imm = eimm; e.rt = ert; e.rd = erd;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    localparam logic [31:0] ADD_8_9_10 = 32'h012A4020;
    localparam logic [31:0] NOP_OP     = 32'hFC000000;
`ifdef WB_BYPASS_EN
    localparam logic [31:0] BYP_A = 32'h00001234;
`else
    localparam logic [31:0] BYP_A = 32'h00000005;
`endif

    initial begin
        @(posedge clock);
        #1;
        step("rst_hold0", 32'h40, ADD_8_9_10, 1'b0, 1'b1, 5'd10, 32'h77, 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0);
        step("rst_hold1", 32'h44, 32'h8D28FFFC, 1'b0, 1'b1, 5'd10, 32'h77, 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("first_after_rst", 32'h4, 32'hFD4A0000, 1'b0, 1'b1, 5'd9, 32'h5, 0, 2'b00, 3'b000, 4'b0000, 32'h4, 0, 0, 0, 5'd10, 5'd0);
        step("preload10", 32'h8, NOP_OP, 1'b0, 1'b1, 5'd10, 32'h7, 0, 2'b00, 3'b000, 4'b0000, 32'h8, 0, 0, 0, 0, 0);
        step("add_rtype", 32'hC, ADD_8_9_10, 1'b0, 1'b0, 5'd0, 0, 0, 2'b10, 3'b000, 4'b1100, 32'hC, 32'd5, 32'd7, 32'h4020, 5'd10, 5'd8);
        step("lw_decode", 32'h10, 32'h8D28FFFC, 1'b0, 1'b0, 5'd0, 0, 0, 2'b11, 3'b010, 4'b0001, 32'h10, 32'd5, 32'd0, 32'hFFFFFFFC, 5'd8, 5'd31);
        step("loaduse_bubble", 32'h14, 32'h01095020, 1'b0, 1'b0, 5'd0, 0, 1, 2'b00, 3'b000, 4'b0000, 32'h14, 32'd0, 32'd5, 32'h5020, 5'd9, 5'd10);
        step("loaduse_retry", 32'h14, 32'h01095020, 1'b0, 1'b0, 5'd0, 0, 0, 2'b10, 3'b000, 4'b1100, 32'h14, 32'd0, 32'd5, 32'h5020, 5'd9, 5'd10);
        step("write_r0", 32'h18, NOP_OP, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 0, 2'b00, 3'b000, 4'b0000, 32'h18, 0, 0, 0, 0, 0);
        step("sw_read_r0", 32'h1C, 32'hAC090008, 1'b0, 1'b0, 5'd0, 0, 0, 2'b00, 3'b001, 4'b0001, 32'h1C, 32'd0, 32'd5, 32'h8, 5'd9, 5'd0);
        step("wb_same_cycle", 32'h20, ADD_8_9_10, 1'b0, 1'b1, 5'd9, 32'h1234, 0, 2'b10, 3'b000, 4'b1100, 32'h20, BYP_A, 32'd7, 32'h4020, 5'd10, 5'd8);
        step("wb_next_cycle", 32'h24, ADD_8_9_10, 1'b0, 1'b0, 5'd0, 0, 0, 2'b10, 3'b000, 4'b1100, 32'h24, 32'h1234, 32'd7, 32'h4020, 5'd10, 5'd8);
        step("flush_rtype", 32'h28, ADD_8_9_10, 1'b1, 1'b0, 5'd0, 0, 0, 2'b00, 3'b000, 4'b0000, 32'h28, 32'h1234, 32'd7, 32'h4020, 5'd10, 5'd8);
        step("beq_decode", 32'h2C, 32'h112AFFFE, 1'b0, 1'b0, 5'd0, 0, 0, 2'b00, 3'b100, 4'b0010, 32'h2C, 32'h1234, 32'd7, 32'hFFFFFFFE, 5'd10, 5'd31);
        step("lw_r10", 32'h30, 32'h8C0A0000, 1'b0, 1'b0, 5'd0, 0, 0, 2'b11, 3'b010, 4'b0001, 32'h30, 32'd0, 32'd7, 32'd0, 5'd10, 5'd0);
        step("flush_and_stall", 32'h34, ADD_8_9_10, 1'b1, 1'b0, 5'd0, 0, 1, 2'b00, 3'b000, 4'b0000, 32'h34, 32'h1234, 32'd7, 32'h4020, 5'd10, 5'd8);
        step("after_flush_stall", 32'h34, ADD_8_9_10, 1'b0, 1'b0, 5'd0, 0, 0, 2'b10, 3'b000, 4'b1100, 32'h34, 32'h1234, 32'd7, 32'h4020, 5'd10, 5'd8);
        step("lw_r0", 32'h38, 32'h8D200000, 1'b0, 1'b0, 5'd0, 0, 0, 2'b11, 3'b010, 4'b0001, 32'h38, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0);
        step("no_stall_rt0", 32'h3C, 32'h00000020, 1'b0, 1'b0, 5'd0, 0, 0, 2'b10, 3'b000, 4'b1100, 32'h3C, 32'd0, 32'd0, 32'h20, 5'd0, 5'd0);
        // Reset is raised just after the edge that captures this slot, so it must read back as zero.
        step("inflight_discard", 32'h50, ADD_8_9_10, 1'b0, 1'b1, 5'd10, 32'h55, 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step("mid_rst_hold", 32'h54, 32'h8D28FFFC, 1'b0, 1'b1, 5'd10, 32'h55, 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("regs_cleared", 32'h58, ADD_8_9_10, 1'b0, 1'b0, 5'd0, 0, 0, 2'b10, 3'b000, 4'b1100, 32'h58, 32'd0, 32'd0, 32'h4020, 5'd10, 5'd8);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
